load_fu: RTL and testbench

- Load functional unit directly downstream of the RS_load_line array.
- Selects one busy load reservation line, performs a word-aligned data-memory read and extracts/extends the byte, half or word.
- Broadcasts the result on the CDB under the line's tag, then pulses FU_result_taken back to that line so it frees.
- Strictly one load in flight; flush aborts it.

---
 rtl/load_fu_pkg.sv | 23 ++
 rtl/load_extend.sv | 35 +++
 rtl/load_fu.sv | 159 +++++++++++++++
 tb/tb_load_fu.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/load_fu_pkg.sv
// Shared constants for the load functional unit:
// access-type encoding, CDB field offsets and FSM state encodings.
package load_fu_pkg;

   // Access type [1:0]; bit 2 set means zero-extend.
   localparam logic [1:0] MEM_B     = 2'b00;
   localparam logic [1:0] MEM_H     = 2'b01;
   localparam logic [1:0] MEM_W     = 2'b10;
   localparam int         MEM_U_BIT = 2;

   // CDB bundle layout {valid, tag, data}.
   localparam int CDB_VALID   = 40;
   localparam int CDB_TAG_HI  = 39;
   localparam int CDB_TAG_LO  = 32;
   localparam int CDB_DATA_HI = 31;
   localparam int CDB_DATA_LO = 0;

   // Load FU states.
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

endpackage

// File: rtl/load_extend.sv
// Extracts the byte/half/word lane from a read word and sign/zero extends it.
// Ports: word_i read word, off_i addr[1:0], type_i access type, res_o result.
module load_extend
   import load_fu_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [1:0]  off_i,
   input  logic [2:0]  type_i,
   output logic [31:0] res_o
);

   logic [7:0]  b;
   logic [15:0] h;
   logic        sx_b;
   logic        sx_h;

   always_comb begin
      unique case (off_i)
         2'd0:    b = word_i[7:0];
         2'd1:    b = word_i[15:8];
         2'd2:    b = word_i[23:16];
         default: b = word_i[31:24];
      endcase
      // Half lane only looks at addr[1].
      h    = off_i[1] ? word_i[31:16] : word_i[15:0];
      sx_b = b[7] & ~type_i[MEM_U_BIT];
      sx_h = h[15] & ~type_i[MEM_U_BIT];
      case (type_i[1:0])
         MEM_B:   res_o = {{24{sx_b}}, b};
         MEM_H:   res_o = {{16{sx_h}}, h};
         default: res_o = word_i;
      endcase
   end

endmodule

// File: rtl/load_fu.sv
// Load FU: picks a busy RS load line round-robin, reads memory, broadcasts on CDB.
// Ports: clk/rst(sync, low), flush, rs_* line inputs, FU_result_taken, mem_* read port, cdb_* bus.
module load_fu
   import load_fu_pkg::*;
#(
   parameter int         NUM_LINES = 3,
   parameter logic [7:0] TAG_BASE  = 8'd16
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic [NUM_LINES-1:0]   rs_busy,
   input  logic [32*NUM_LINES-1:0] rs_addr,
   input  logic [3*NUM_LINES-1:0] rs_mem_u_b_h_w,
   output logic [NUM_LINES-1:0]   FU_result_taken,
   output logic                   mem_req,
   output logic [31:0]            mem_addr,
   input  logic                   mem_ack,
   input  logic [31:0]            mem_rdata,
   output logic                   cdb_req,
   input  logic                   cdb_grant,
   output logic [40:0]            cdb
);

   localparam int IW  = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
   localparam int IW1 = IW + 1;
   localparam logic [IW-1:0] LAST_RST = IW'(NUM_LINES - 1);

   logic [1:0]    state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [IW-1:0] last_q, last_d;
   logic [31:0]   addr_q, addr_d;
   logic [2:0]    type_q, type_d;
   logic [31:0]   data_q, data_d;

   logic [IW-1:0] pick;
   logic [IW:0]   cand;
   logic          found;
   logic [31:0]   sel_addr;
   logic [2:0]    sel_type;
   logic [31:0]   ext;
   logic          fire;

   load_extend u_ext (
      .word_i (mem_rdata),
      .off_i  (addr_q[1:0]),
      .type_i (type_q),
      .res_o  (ext)
   );

   // Round-robin: scan from farthest to nearest so the line right
   // after last_q overrides all others.
   always_comb begin
      pick  = last_q;
      found = 1'b0;
      cand  = '0;
      for (int i = NUM_LINES; i >= 1; i--) begin
         cand = {1'b0, last_q} + IW1'(i);
         if (cand >= IW1'(NUM_LINES))
            cand = cand - IW1'(NUM_LINES);
         if (rs_busy[cand[IW-1:0]]) begin
            pick  = cand[IW-1:0];
            found = 1'b1;
         end
      end
   end

   always_comb begin
      sel_addr = '0;
      sel_type = '0;
      for (int j = 0; j < NUM_LINES; j++) begin
         if (pick == IW'(j)) begin
            sel_addr = rs_addr[32*j +: 32];
            sel_type = rs_mem_u_b_h_w[3*j +: 3];
         end
      end
   end

   // Flush and reset both suppress the broadcast even with a grant.
   assign fire = (state_q == S_RESP) & cdb_grant & ~flush & rst;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      last_d  = last_q;
      addr_d  = addr_q;
      type_d  = type_q;
      data_d  = data_q;
      case (state_q)
         S_IDLE: begin
            if (found) begin
               idx_d   = pick;
               addr_d  = sel_addr;
               type_d  = sel_type;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (mem_ack) begin
               data_d  = ext;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (cdb_grant) begin
               last_d  = idx_q;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (flush) begin
         state_d = S_IDLE;
         idx_d   = idx_q;
         addr_d  = addr_q;
         type_d  = type_q;
         data_d  = data_q;
         last_d  = last_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         last_q  <= LAST_RST;
         addr_q  <= '0;
         type_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
         addr_q  <= addr_d;
         type_q  <= type_d;
         data_q  <= data_d;
      end
   end

   assign mem_req  = (state_q == S_REQ);
   assign mem_addr = {addr_q[31:2], 2'b00};
   assign cdb_req  = (state_q == S_RESP);

   always_comb begin
      cdb = '0;
      if (cdb_req) begin
         cdb[CDB_VALID]              = fire;
         cdb[CDB_TAG_HI:CDB_TAG_LO]  = TAG_BASE + 8'(idx_q);
         cdb[CDB_DATA_HI:CDB_DATA_LO] = data_q;
      end
   end

   always_comb begin
      FU_result_taken = '0;
      if (fire)
         FU_result_taken[idx_q] = 1'b1;
   end

endmodule

// File: tb/tb_load_fu.sv
// Directed self-checking bench for load_fu.
// Table of single loads plus hand sequences for stall, flush and reset.
module tb_load_fu;

   localparam int NL = 3;
   localparam logic [7:0] TB = 8'd16;

   logic          clk;
   logic          rst;
   logic          flush;
   logic [NL-1:0] rs_busy;
   logic [32*NL-1:0] rs_addr;
   logic [3*NL-1:0] rs_type;
   logic [NL-1:0] taken;
   logic          mem_req;
   logic [31:0]   mem_addr;
   logic          mem_ack;
   logic [31:0]   mem_rdata;
   logic          cdb_req;
   logic          cdb_grant;
   logic [40:0]   cdb;

   int n_checks = 0;
   int n_fail   = 0;

   load_fu #(.NUM_LINES(NL), .TAG_BASE(TB)) dut (
      .clk             (clk),
      .rst             (rst),
      .flush           (flush),
      .rs_busy         (rs_busy),
      .rs_addr         (rs_addr),
      .rs_mem_u_b_h_w  (rs_type),
      .FU_result_taken (taken),
      .mem_req         (mem_req),
      .mem_addr        (mem_addr),
      .mem_ack         (mem_ack),
      .mem_rdata       (mem_rdata),
      .cdb_req         (cdb_req),
      .cdb_grant       (cdb_grant),
      .cdb             (cdb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      logic [2:0]  typ;
      logic [31:0] rdata;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // One complete load on line ln; aw/gw are ack and grant wait cycles.
   task automatic do_load(input int ln, input logic [31:0] a,
                          input logic [2:0] t, input logic [31:0] rd,
                          input int aw, input int gw,
                          input logic [31:0] exp, input bit keep,
                          input string nm);
      logic [7:0] tag;
      logic [NL-1:0] oh;
      tag = TB + 8'(ln);
      oh  = '0;
      oh[ln] = 1'b1;
      rs_addr[32*ln +: 32] = a;
      rs_type[3*ln +: 3]   = t;
      rs_busy[ln]          = 1'b1;
      cyc();
      chk({nm, " mem_req"}, 64'(mem_req), 64'd1);
      chk({nm, " mem_addr"}, 64'(mem_addr), 64'({a[31:2], 2'b00}));
      for (int k = 0; k < aw; k++) begin
         cyc();
         chk({nm, " req hold"}, 64'({mem_req, cdb_req}), 64'(2'b10));
         chk({nm, " addr hold"}, 64'(mem_addr), 64'({a[31:2], 2'b00}));
      end
      mem_ack   = 1'b1;
      mem_rdata = rd;
      cyc();
      mem_ack   = 1'b0;
      mem_rdata = 32'h0BAD_F00D;
      #1;
      chk({nm, " resp"}, 64'({mem_req, cdb_req}), 64'(2'b01));
      for (int k = 0; k < gw; k++) begin
         chk({nm, " cdb hold"}, 64'(cdb), 64'({1'b0, tag, exp}));
         chk({nm, " no pulse"}, 64'(taken), 64'd0);
         cyc();
      end
      cdb_grant = 1'b1;
      #1;
      chk({nm, " cdb"}, 64'(cdb), 64'({1'b1, tag, exp}));
      chk({nm, " taken"}, 64'(taken), 64'(oh));
      if (!keep) rs_busy[ln] = 1'b0;
      cyc();
      cdb_grant = 1'b0;
      #1;
      chk({nm, " pulse end"}, 64'(taken), 64'd0);
      chk({nm, " idle"}, 64'({mem_req, cdb_req}), 64'd0);
   endtask

   initial begin
      vecs[0] = '{32'h100, 3'b010, 32'hDEADBEEF, 32'hDEADBEEF};
      vecs[1] = '{32'h103, 3'b000, 32'h80112233, 32'hFFFFFF80};
      vecs[2] = '{32'h103, 3'b100, 32'h80112233, 32'h00000080};
      vecs[3] = '{32'h102, 3'b001, 32'h80112233, 32'hFFFF8011};
      vecs[4] = '{32'h101, 3'b101, 32'h80112233, 32'h00002233};
      vecs[5] = '{32'h100, 3'b110, 32'h80112233, 32'h80112233};
      vecs[6] = '{32'h102, 3'b011, 32'h80112233, 32'h80112233};
      vecs[7] = '{32'h101, 3'b000, 32'h80112233, 32'h00000022};

      rst = 1'b0; flush = 1'b0; rs_busy = '0; rs_addr = '0;
      rs_type = '0; mem_ack = 1'b0; mem_rdata = '0; cdb_grant = 1'b0;
      cyc();
      cyc();
      chk("rst mem_req", 64'(mem_req), 64'd0);
      chk("rst mem_addr", 64'(mem_addr), 64'd0);
      chk("rst cdb_req", 64'(cdb_req), 64'd0);
      chk("rst cdb", 64'(cdb), 64'd0);
      chk("rst taken", 64'(taken), 64'd0);
      rst = 1'b1;

      // Round-robin with all lines busy: 0,1,2,0.
      rs_busy = 3'b111;
      do_load(0, 32'h400, 3'b010, 32'h11110000, 0, 0, 32'h11110000, 1, "rr0");
      do_load(1, 32'h404, 3'b010, 32'h22221111, 0, 0, 32'h22221111, 1, "rr1");
      do_load(2, 32'h408, 3'b010, 32'h33332222, 0, 0, 32'h33332222, 1, "rr2");
      do_load(0, 32'h400, 3'b010, 32'h44443333, 0, 0, 32'h44443333, 1, "rr3");
      rs_busy = '0;
      cyc();

      for (int v = 0; v < 8; v++)
         do_load(0, vecs[v].addr, vecs[v].typ, vecs[v].rdata, 0, 0,
                 vecs[v].exp, 0, $sformatf("vec%0d", v));

      do_load(1, 32'h106, 3'b001, 32'hABCD1234, 4, 3, 32'hFFFFABCD, 0, "stall");

      // Flush in REQ coinciding with mem_ack.
      rs_addr[63:32] = 32'h200;
      rs_type[5:3]   = 3'b010;
      rs_busy        = 3'b010;
      cyc();
      chk("fl req", 64'(mem_req), 64'd1);
      flush = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h55555555;
      #1;
      chk("fl req valid", 64'(cdb[40]), 64'd0);
      chk("fl req taken", 64'(taken), 64'd0);
      cyc();
      flush = 1'b0; mem_ack = 1'b0;
      chk("fl req idle", 64'({mem_req, cdb_req}), 64'd0);
      do_load(1, 32'h204, 3'b010, 32'h66666666, 0, 0, 32'h66666666, 0, "after fl");

      // Flush in RESP coinciding with grant.
      rs_addr[95:64] = 32'h300;
      rs_type[8:6]   = 3'b010;
      rs_busy        = 3'b100;
      cyc();
      mem_ack = 1'b1; mem_rdata = 32'h77777777;
      cyc();
      mem_ack = 1'b0;
      chk("fl resp req", 64'(cdb_req), 64'd1);
      flush = 1'b1; cdb_grant = 1'b1;
      #1;
      chk("fl resp valid", 64'(cdb[40]), 64'd0);
      chk("fl resp taken", 64'(taken), 64'd0);
      rs_busy = '0;
      cyc();
      flush = 1'b0; cdb_grant = 1'b0;
      #1;
      chk("fl resp idle", 64'({mem_req, cdb_req}), 64'd0);

      // Reset in RESP; last_served must return to line 0 priority.
      rs_busy = 3'b010;
      cyc();
      mem_ack = 1'b1; mem_rdata = 32'h88888888;
      cyc();
      mem_ack = 1'b0;
      chk("rs resp req", 64'(cdb_req), 64'd1);
      rst = 1'b0; cdb_grant = 1'b1;
      #1;
      chk("rs taken", 64'(taken), 64'd0);
      rs_busy = '0;
      cyc();
      cdb_grant = 1'b0;
      #1;
      chk("rs2 mem_req", 64'(mem_req), 64'd0);
      chk("rs2 mem_addr", 64'(mem_addr), 64'd0);
      chk("rs2 cdb_req", 64'(cdb_req), 64'd0);
      chk("rs2 cdb", 64'(cdb), 64'd0);
      chk("rs2 taken", 64'(taken), 64'd0);
      rst = 1'b1;
      rs_busy = 3'b111;
      do_load(0, 32'h500, 3'b010, 32'h99999999, 0, 0, 32'h99999999, 1, "post rst");
      rs_busy = '0;
      cyc();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
